// File: rtl/fir_seq_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// fir_seq_ctrl_if : host streams, result port and FIR control pins
// Rev 1.0
//------------------------------------------------------------------------------
interface fir_seq_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_data;
  logic        smp_valid;
  logic        smp_ready;
  logic [15:0] smp_data;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        err_timeout;
  logic        busy;
  logic        fir_wind;
  logic        fir_load;
  logic [15:0] fir_data;
  logic        fir_in_valid;
  logic        fir_out_valid;
  logic [15:0] fir_out;

  // master: the sequencer; slave: host fabric plus FIR instance
  modport master (
    input  cfg_valid, cfg_data, smp_valid, smp_data, res_ready,
           fir_out_valid, fir_out,
    output cfg_ready, smp_ready, res_valid, res_data, err_timeout, busy,
           fir_wind, fir_load, fir_data, fir_in_valid
  );

  modport slave (
    output cfg_valid, cfg_data, smp_valid, smp_data, res_ready,
           fir_out_valid, fir_out,
    input  cfg_ready, smp_ready, res_valid, res_data, err_timeout, busy,
           fir_wind, fir_load, fir_data, fir_in_valid
  );
endinterface
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// fir_seq_ctrl : sequencer owning the FIR weight/data/compute controls
// Rev 1.0
//------------------------------------------------------------------------------
module fir_seq_ctrl #(
  parameter int NTAPS     = 16,
  parameter int IV_CYCLES = 4,
  parameter int TIMEOUT   = 31
) (
  input  logic          clk,
  input  logic          rstb,
  fir_seq_ctrl_if.master bus
);
  localparam int CNT_M1 = (NTAPS > IV_CYCLES) ? NTAPS : IV_CYCLES;
  localparam int CNT_MX = (CNT_M1 > TIMEOUT) ? CNT_M1 : TIMEOUT;
  localparam int CNT_W  = $clog2(CNT_MX + 1);
  localparam int FILL_W = $clog2(NTAPS + 1);

  localparam logic [CNT_W-1:0]  c_beat_last = CNT_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0]  c_iv_end    = CNT_W'(IV_CYCLES);
  localparam logic [CNT_W-1:0]  c_tmo_last  = CNT_W'(TIMEOUT - 1);
  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(NTAPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_DLOAD = 3'd2,
    S_FIRE  = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [FILL_W-1:0]  r_fill_cnt;
  logic               r_w_loaded;
  logic               r_cfg_ready;
  logic               r_smp_ready;
  logic               r_res_valid;
  logic [15:0]        r_res_data;
  logic               r_err_timeout;
  logic               r_fir_wind;
  logic               r_fir_load;
  logic [15:0]        r_fir_data;
  logic               r_fir_in_valid;

  logic               w_cfg_acc;
  logic               w_smp_acc;
  logic [FILL_W-1:0]  w_fill_inc;

  assign w_cfg_acc  = r_cfg_ready & bus.cfg_valid;
  assign w_smp_acc  = r_smp_ready & bus.smp_valid;
  assign w_fill_inc = (r_fill_cnt == c_fill_full) ? r_fill_cnt : r_fill_cnt + 1'b1;

  // One counter serves as beat, in_valid and timeout counter; each state clears it on exit
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_fill_cnt     <= '0;
      r_w_loaded     <= 1'b0;
      r_cfg_ready    <= 1'b0;
      r_smp_ready    <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_err_timeout  <= 1'b0;
      r_fir_wind     <= 1'b0;
      r_fir_load     <= 1'b0;
      r_fir_data     <= '0;
      r_fir_in_valid <= 1'b0;
    end else begin
      r_fir_wind     <= 1'b0;
      r_fir_load     <= 1'b0;
      r_fir_in_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.cfg_valid) begin
            r_state     <= S_WLOAD;
            r_cfg_ready <= 1'b1;
          end else if (bus.smp_valid && r_w_loaded) begin
            r_state     <= S_DLOAD;
            r_smp_ready <= 1'b1;
          end
        end
        S_WLOAD: begin
          if (w_cfg_acc) begin
            r_fir_wind <= 1'b1;
            r_fir_data <= bus.cfg_data;
            if (r_cnt == c_beat_last) begin
              r_w_loaded    <= 1'b1;
              r_err_timeout <= 1'b0;
              r_cfg_ready   <= 1'b0;
              r_cnt         <= '0;
              r_state       <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DLOAD: begin
          // Priming keeps accepting until the window is full; a full window takes one beat
          if (w_smp_acc) begin
            r_fir_load <= 1'b1;
            r_fir_data <= bus.smp_data;
            r_fill_cnt <= w_fill_inc;
            if (w_fill_inc == c_fill_full) begin
              r_smp_ready <= 1'b0;
              r_cnt       <= '0;
              r_state     <= S_FIRE;
            end
          end
        end
        S_FIRE: begin
          if (r_cnt == c_iv_end) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_fir_in_valid <= 1'b1;
            r_cnt          <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.fir_out_valid) begin
            r_res_data  <= bus.fir_out;
            r_res_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_RESP;
          end else if (r_cnt == c_tmo_last) begin
            r_err_timeout <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_cfg_ready <= 1'b0;
          r_smp_ready <= 1'b0;
          r_res_valid <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready    = r_cfg_ready;
  assign bus.smp_ready    = r_smp_ready;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.err_timeout  = r_err_timeout;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.fir_wind     = r_fir_wind;
  assign bus.fir_load     = r_fir_load;
  assign bus.fir_data     = r_fir_data;
  assign bus.fir_in_valid = r_fir_in_valid;
endmodule
`default_nettype wire
